func_sqr_cbrt: RTL and testbench

Sequencer that evaluates y = a² + ∛b for an 8-bit a and a 16-bit b. It is the consumer stage of the team's integer cube-root unit (`cbrt`). It launches that unit through a start/busy handshake, squares a with its own shift-add multiplier while the root runs, then sums both results. Its ports to the cube-root unit are exposed so the block can be verified against a behavioural model.

---
 rtl/func_sqr_cbrt.sv | 154 +++++++++++++++
 tb/tb_func_sqr_cbrt.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/func_sqr_cbrt.sv
// func_sqr_cbrt: y = a*a + cbrt(b) sequencer.
// Launches the external cube-root unit over a start/busy handshake, squares a
// with an 8-step shift-add multiplier meanwhile, then sums both results.
// Optional feature macro FUNC_TIMEOUT_EN: watchdog on the cube-root handshake
// (parameter TIMEOUT, output err_o).
module func_sqr_cbrt
`ifdef FUNC_TIMEOUT_EN
  #(parameter int TIMEOUT = 4095)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  a_bi,
  input  logic [15:0] b_bi,
  output logic        busy_o,
  output logic        valid_o,
  output logic [15:0] y_bo,
`ifdef FUNC_TIMEOUT_EN
  output logic        err_o,
`endif
  output logic        cbrt_start,
  output logic [15:0] cbrt_x,
  input  logic [1:0]  cbrt_busy,
  input  logic [15:0] cbrt_out
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE, SQR_ONLY} state_t;

  state_t      state;
  logic [7:0]  a_r;
  logic        b_lsb;
  logic [15:0] sq_acc, sq_add, sq_nxt, sq_fin;
  logic [2:0]  sq_cnt;
  logic        sq_run, sq_done, sq_ready;
  logic        accept, root_fin;
  logic        unused_hi;

  // The root never exceeds 40, so only its low byte matters.
  assign unused_hi = ^cbrt_out[15:8];

  assign accept   = (state == IDLE) && start_i;
  assign sq_add   = a_r[sq_cnt] ? ({8'd0, a_r} << sq_cnt) : 16'd0;
  assign sq_nxt   = sq_acc + sq_add;
  // Ready already during the last iteration so the result lands in cycle 9.
  assign sq_ready = sq_done | (sq_run & (sq_cnt == 3'd7));
  assign sq_fin   = sq_done ? sq_acc : sq_nxt;
  assign root_fin = (state == WAIT_DONE) && (cbrt_busy == 2'd0) && sq_ready;

`ifdef FUNC_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT - 1);
  logic [15:0] to_cnt;
  logic        to_hit;
  assign to_hit = ((state == WAIT_ACK) || (state == WAIT_DONE)) && (to_cnt == TO_LIM);
`endif

  // Shift-add squarer: one multiplier bit per cycle, starting after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      sq_acc  <= '0;
      sq_cnt  <= '0;
      sq_run  <= 1'b0;
      sq_done <= 1'b0;
    end else if (accept) begin
      a_r     <= a_bi;
      sq_acc  <= '0;
      sq_cnt  <= '0;
      sq_run  <= 1'b1;
      sq_done <= 1'b0;
    end else if (sq_run) begin
      sq_acc <= sq_nxt;
      sq_cnt <= sq_cnt + 3'd1;
      if (sq_cnt == 3'd7) begin
        sq_run  <= 1'b0;
        sq_done <= 1'b1;
      end
    end
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      valid_o    <= 1'b0;
      y_bo       <= '0;
      cbrt_start <= 1'b0;
      cbrt_x     <= '0;
      b_lsb      <= 1'b0;
`ifdef FUNC_TIMEOUT_EN
      err_o      <= 1'b0;
      to_cnt     <= '0;
`endif
    end else begin
      valid_o    <= 1'b0;
      cbrt_start <= 1'b0;
`ifdef FUNC_TIMEOUT_EN
      if ((state == WAIT_ACK) || (state == WAIT_DONE)) to_cnt <= to_cnt + 16'd1;
`endif
      unique case (state)
        IDLE: begin
          if (start_i) begin
            busy_o <= 1'b1;
            b_lsb  <= b_bi[0];
`ifdef FUNC_TIMEOUT_EN
            err_o  <= 1'b0;
            to_cnt <= '0;
`endif
            // b of 0 or 1 is its own root; skip the external unit.
            if (b_bi < 16'd2) begin
              state <= SQR_ONLY;
            end else begin
              cbrt_x     <= b_bi;
              cbrt_start <= 1'b1;
              state      <= WAIT_ACK;
            end
          end
        end
        WAIT_ACK: begin
          if (cbrt_busy != 2'd0) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (root_fin) begin
            y_bo    <= sq_fin + {8'd0, cbrt_out[7:0]};
            valid_o <= 1'b1;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end
        end
        SQR_ONLY: begin
          if (sq_ready) begin
            y_bo    <= sq_fin + {15'd0, b_lsb};
            valid_o <= 1'b1;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef FUNC_TIMEOUT_EN
      // Watchdog: abandon the root and flag the error; a real result wins a tie.
      if (to_hit && !root_fin) begin
        y_bo    <= 16'hFFFF;
        valid_o <= 1'b1;
        busy_o  <= 1'b0;
        err_o   <= 1'b1;
        state   <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_func_sqr_cbrt.sv
// Scoreboard bench for func_sqr_cbrt with a behavioural cube-root unit.
module tb_func_sqr_cbrt;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  a_bi = '0;
  logic [15:0] b_bi = '0;
  logic        busy_o, valid_o, cbrt_start;
  logic [15:0] y_bo, cbrt_x, cbrt_out;
  logic [1:0]  cbrt_busy;
`ifdef FUNC_TIMEOUT_EN
  logic        err_o;
`endif

  always #5 clk = ~clk;

`ifdef FUNC_TIMEOUT_EN
  func_sqr_cbrt #(.TIMEOUT(50)) dut (
`else
  func_sqr_cbrt dut (
`endif
    .clk(clk), .rst(rst), .start_i(start_i), .a_bi(a_bi), .b_bi(b_bi),
    .busy_o(busy_o), .valid_o(valid_o), .y_bo(y_bo),
`ifdef FUNC_TIMEOUT_EN
    .err_o(err_o),
`endif
    .cbrt_start(cbrt_start), .cbrt_x(cbrt_x), .cbrt_busy(cbrt_busy), .cbrt_out(cbrt_out));

  typedef struct {logic [15:0] y; int cyc;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int cyc = 0;
  int start_pulses = 0;

  // Behavioural cube-root unit: latency model_lat busy cycles, hold freezes it.
  int       model_lat = 3;
  bit       hold = 0;
  int       m_cnt = 0;
  logic [7:0] m_res = '0;

  function automatic logic [7:0] icbrt(input logic [15:0] x);
    int r = 0;
    for (int i = 0; i <= 40; i++) if (i * i * i <= int'(x)) r = i;
    return 8'(r);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) m_cnt <= 0;
    else if (cbrt_start) begin
      m_cnt <= model_lat;
      m_res <= icbrt(cbrt_x);
    end else if (m_cnt != 0 && !hold) m_cnt <= m_cnt - 1;
  end
  assign cbrt_busy = (m_cnt != 0) ? 2'b01 : 2'b00;
  assign cbrt_out  = {8'hA5, m_res};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) if (cbrt_start) start_pulses++;

  // Monitor: every valid pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got y=%0d expected no valid", y_bo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("y_bo", 32'(y_bo), 32'(e.y));
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_at_valid", 32'(busy_o), 32'd0);
      end
    end
  end

  task automatic run(input logic [7:0] a, input logic [15:0] b, input int lat,
                     input logic [15:0] ey, input int elat, input int estarts, input bit glitch);
    int sp0, n;
    exp_t e;
    @(negedge clk);
    a_bi = a; b_bi = b; start_i = 1'b1; model_lat = lat;
    e.y = ey; e.cyc = cyc + elat;
    sb.push_back(e);
    sp0 = start_pulses;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_cycle1", 32'(busy_o), 32'd1);
    chk("cbrt_start_cycle1", 32'(cbrt_start), (b >= 16'd2) ? 32'd1 : 32'd0);
    if (b >= 16'd2) chk("cbrt_x", 32'(cbrt_x), 32'(b));
    if (glitch) begin
      @(negedge clk);
      a_bi = 8'd200; b_bi = 16'd9; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL result_timeout: got no valid in 200 cycles expected y=%0d", ey);
      sb.delete();
    end
    chk("cbrt_start_pulses", 32'(start_pulses - sp0), 32'(estarts));
  endtask

  initial begin
    int sp0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_y", 32'(y_bo), 32'd0);
    chk("rst_cbrt_start", 32'(cbrt_start), 32'd0);
    chk("rst_cbrt_x", 32'(cbrt_x), 32'd0);
    rst = 1'b0;

    run(8'd3,   16'd27,    20, 16'd12,    23, 1, 0);
    run(8'd255, 16'd65535, 10, 16'd65065, 13, 1, 0);
    run(8'd5,   16'd0,     3,  16'd25,    9,  0, 0);
    run(8'd0,   16'd1,     3,  16'd1,     9,  0, 0);
    run(8'd10,  16'd26,    3,  16'd102,   9,  1, 1);

    // Abort in WAIT_DONE: no result expected.
    @(negedge clk);
    a_bi = 8'd7; b_bi = 16'd100; start_i = 1'b1; model_lat = 30;
    sp0 = start_pulses;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_y", 32'(y_bo), 32'd0);
    chk("abort_valid", 32'(valid_o), 32'd0);
    chk("abort_cbrt_start", 32'(cbrt_start), 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_no_relaunch", 32'(start_pulses - sp0), 32'd1);

    run(8'd2, 16'd8, 5, 16'd6, 9, 1, 0);

`ifdef FUNC_TIMEOUT_EN
    hold = 1;
    run(8'd1, 16'd9, 3, 16'hFFFF, 51, 1, 0);
    chk("err_set", 32'(err_o), 32'd1);
    repeat (5) @(negedge clk);
    chk("err_sticky", 32'(err_o), 32'd1);
    hold = 0;
    for (int i = 0; i < 20 && cbrt_busy != 2'd0; i++) @(negedge clk);
    run(8'd3, 16'd0, 3, 16'd9, 9, 0, 0);
    chk("err_cleared", 32'(err_o), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end
endmodule
